// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction fetch unit
package ifu_pkg;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] EBREAK_INST = 32'h00100073;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;
    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with synchronous flush and occupancy count
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    assign dout = mem[rd_ptr];
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC holder and imem requester feeding decode through a fetch buffer;
// IFU_EBREAK_HALT_EN makes a consumed ebreak stop fetch until reset.
module ifu_fetch import ifu_pkg::*; #(
    parameter int              AW         = 32,
    parameter logic [AW-1:0]   RESET_PC   = AW'(32'h8000_0000),
    parameter int              FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [AW-1:0]     imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [AW-1:0]     pc,
    input  logic              redirect_valid,
    input  logic [AW-1:0]     redirect_pc,
    output logic              halted
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t               state, state_n;
    logic [AW-1:0]        fetch_pc, held_addr;
    logic                 drop_pend, drop_n, held;
    logic [CW-1:0]        count;
    logic [AW+INST_W-1:0] head;
    logic                 req_hs, push, pop, flush, redir, halt_go;

    // a request is only offered when its response already has a free slot
    assign imem_req_valid = !rst && state == S_REQ && count < CW'(FIFO_DEPTH);
    // a stalled request keeps its original address even if fetch_pc is redirected
    assign imem_req_addr  = rst ? RESET_PC : held ? held_addr : fetch_pc;
    assign req_hs         = imem_req_valid && imem_req_ready;
    assign redir          = redirect_valid && state != S_HALT;
    assign inst_valid     = count != '0 && state != S_HALT;
    assign pop            = inst_valid && inst_ready;
    assign push           = state == S_WAIT && imem_rsp_valid && !drop_pend && !redirect_valid;
    assign {pc, inst}     = head;
`ifdef IFU_EBREAK_HALT_EN
    assign halt_go = pop && inst == EBREAK_INST;
    assign halted  = state == S_HALT;
`else
    assign halt_go = 1'b0;
    assign halted  = 1'b0;
`endif
    assign flush = redir || halt_go || state == S_HALT;

    always_comb begin
        state_n = halt_go ? S_HALT :
                  (state == S_REQ && req_hs) ? S_WAIT :
                  (state == S_WAIT && imem_rsp_valid) ? S_REQ : state;
        // drop_pend marks the one outstanding (or still-stalled) request as wrong-path
        drop_n  = state == S_HALT ? 1'b0 :
                  state == S_WAIT ? !imem_rsp_valid && (drop_pend || redirect_valid) :
                  drop_pend || (redirect_valid && imem_req_valid);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            fetch_pc  <= RESET_PC;
            drop_pend <= 1'b0;
            held      <= 1'b0;
            held_addr <= RESET_PC;
        end else begin
            state     <= state_n;
            drop_pend <= drop_n;
            held      <= imem_req_valid && !imem_req_ready;
            held_addr <= imem_req_addr;
            if (redir) fetch_pc <= redirect_pc & ~AW'(3);
            else if (push) fetch_pc <= fetch_pc + AW'(4);
        end
    end

    ifu_fifo #(.DEPTH(FIFO_DEPTH), .W(AW + INST_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   ({fetch_pc, imem_rsp_data}),
        .dout  (head),
        .count (count)
    );
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench for ifu_fetch with a latency-configurable imem model
module tb_ifu_fetch;
    import ifu_pkg::*;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] EBK_PC = 32'h8000_0408;

    logic        clk = 1'b0;
    logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [31:0] imem_req_addr, imem_rsp_data, inst, pc, redirect_pc;
    logic        inst_valid, inst_ready, redirect_valid, halted;
    int          checks = 0, failures = 0, pops = 0, lat = 1;
    fetch_entry_t q[$];
    fetch_entry_t exp;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == EBK_PC) ? EBREAK_INST : {~a[15:0], a[31:16]};
    endfunction

    function automatic void expect_from(input logic [31:0] a);
        q.delete();
        for (int i = 0; i < 64; i++) q.push_back('{pc: a + 32'(4 * i), inst: memf(a + 32'(4 * i))});
    endfunction

    // imem: samples the request handshake away from the edge, answers lat cycles later
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) mem_pend = 1'b0;
            else if (imem_req_valid && imem_req_ready) begin
                mem_pend = 1'b1;
                mem_cnt  = lat;
                mem_addr = imem_req_addr;
            end
            @(posedge clk);
            #2;
            imem_rsp_valid = 1'b0;
            if (mem_pend) begin
                mem_cnt = mem_cnt - 1;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = memf(mem_addr);
                    mem_pend       = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid: got %b exp 0", inst_valid); end
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b exp 0", imem_req_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted: got %b exp 0", halted); end
        checks++; if (imem_req_addr !== RST_PC) begin failures++; $display("FAIL reset_addr: got %h exp %h", imem_req_addr, RST_PC); end
        expect_from(RST_PC);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b1) begin failures++; $display("FAIL c0_req_valid: got %b exp 1", imem_req_valid); end
        checks++; if (imem_req_addr !== RST_PC) begin failures++; $display("FAIL c0_addr: got %h exp %h", imem_req_addr, RST_PC); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL c1_inst_valid: got %b exp 0", inst_valid); end
        @(posedge clk); #1; @(negedge clk);
        checks++; if (inst_valid !== 1'b1) begin failures++; $display("FAIL c2_inst_valid: got %b exp 1", inst_valid); end
        checks++; if ({pc, inst} !== {RST_PC, memf(RST_PC)}) begin failures++; $display("FAIL c2_head: got %h/%h exp %h/%h", pc, inst, RST_PC, memf(RST_PC)); end
        checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, RST_PC + 32'd4}) begin failures++; $display("FAIL c2_req: got %b/%h exp 1/%h", imem_req_valid, imem_req_addr, RST_PC + 32'd4); end
        @(posedge clk); #1;
        inst_ready = 1'b1;
        pops = 0;
        repeat (20) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                if (q.size() != 0) exp = q.pop_front(); else exp = '1;
                checks++; pops++;
                if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
            end
            @(posedge clk); #1;
        end
        checks++; if (pops != 11) begin failures++; $display("FAIL stream_rate: got %0d pops exp 11", pops); end
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (inst_valid) begin
                checks++;
                if (pc !== q[0].pc) begin failures++; $display("FAIL stall_head: got %h exp %h", pc, q[0].pc); end
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL full_req_valid: got %b exp 0", imem_req_valid); end
        @(posedge clk); #1;
        inst_ready = 1'b1;
        // exactly two buffered entries drain back to back, then a gap while refetching
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (inst_valid !== 1'(i < 2)) begin failures++; $display("FAIL drain_valid%0d: got %b exp %b", i, inst_valid, i < 2); end
            if (inst_valid && inst_ready) begin
                if (q.size() != 0) exp = q.pop_front(); else exp = '1;
                checks++; pops++;
                if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
            end
            @(posedge clk); #1;
        end
        repeat (8) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                if (q.size() != 0) exp = q.pop_front(); else exp = '1;
                checks++; pops++;
                if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_wait();
        bit found = 0, seen = 0;
        int p0;
        lat = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                if (q.size() != 0) exp = q.pop_front(); else exp = '1;
                checks++; pops++;
                if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
            end
            if (imem_req_valid && imem_req_ready) found = 1;
            @(posedge clk); #1;
        end
        checks++; if (!found) begin failures++; $display("FAIL wait_hs_timeout: got none exp handshake"); end
        inst_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0103; lat = 1;
        @(negedge clk);
        expect_from(32'h8000_0100);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL flush_empty: got %b exp 0", inst_valid); end
        @(posedge clk); #1;
        inst_ready = 1'b1;
        p0 = pops;
        repeat (20) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                if (q.size() != 0) exp = q.pop_front(); else exp = '1;
                checks++; pops++;
                if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
            end
            if (imem_req_valid && imem_req_ready && !seen) begin
                seen = 1;
                checks++; if (imem_req_addr !== 32'h8000_0100) begin failures++; $display("FAIL redir_addr: got %h exp 80000100", imem_req_addr); end
            end
            @(posedge clk); #1;
        end
        checks++; if (pops - p0 < 5) begin failures++; $display("FAIL redir_progress: got %0d pops exp >=5", pops - p0); end
    endtask

    task automatic test_redirect_rsp_pop();
        bit found = 0;
        int p0;
        inst_ready = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (inst_valid && imem_req_valid && imem_req_ready) found = 1;
            @(posedge clk); #1;
        end
        checks++; if (!found) begin failures++; $display("FAIL rsp_pop_setup_timeout: got none exp setup"); end
        inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        p0 = pops;
        @(negedge clk);
        if (inst_valid && inst_ready) begin
            if (q.size() != 0) exp = q.pop_front(); else exp = '1;
            checks++; pops++;
            if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
        end
        checks++; if (pops != p0 + 1) begin failures++; $display("FAIL redir_pop_counted: got %0d exp %0d", pops - p0, 1); end
        expect_from(32'h8000_0200);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rsp_not_pushed: got %b exp 0", inst_valid); end
        checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0200}) begin failures++; $display("FAIL next_req: got %b/%h exp 1/80000200", imem_req_valid, imem_req_addr); end
        @(posedge clk); #1;
        p0 = pops;
        repeat (10) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                if (q.size() != 0) exp = q.pop_front(); else exp = '1;
                checks++; pops++;
                if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
            end
            @(posedge clk); #1;
        end
        checks++; if (pops - p0 < 3) begin failures++; $display("FAIL rsp_pop_progress: got %0d pops exp >=3", pops - p0); end
    endtask

    task automatic test_req_stall();
        bit found = 0;
        int hs_n = 0;
        logic [31:0] a0 = '0;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                if (q.size() != 0) exp = q.pop_front(); else exp = '1;
                checks++; pops++;
                if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
            end
            if (imem_req_valid) begin found = 1; a0 = imem_req_addr; end
            @(posedge clk); #1;
        end
        checks++; if (!found) begin failures++; $display("FAIL stall_req_timeout: got none exp req_valid"); end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                if (q.size() != 0) exp = q.pop_front(); else exp = '1;
                checks++; pops++;
                if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
            end
            checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, a0}) begin failures++; $display("FAIL held_req%0d: got %b/%h exp 1/%h", i, imem_req_valid, imem_req_addr, a0); end
            if (i == 0) expect_from(32'h8000_0300);
            @(posedge clk); #1;
            redirect_valid = 1'b0;
        end
        imem_req_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (inst_valid && inst_ready) begin
                if (q.size() != 0) exp = q.pop_front(); else exp = '1;
                checks++; pops++;
                if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
            end
            if (imem_req_valid && imem_req_ready) begin
                hs_n++;
                if (hs_n == 1) begin
                    checks++; if (imem_req_addr !== a0) begin failures++; $display("FAIL stale_req_addr: got %h exp %h", imem_req_addr, a0); end
                end
                if (hs_n == 2) begin
                    checks++; if (imem_req_addr !== 32'h8000_0300) begin failures++; $display("FAIL new_req_addr: got %h exp 80000300", imem_req_addr); end
                end
            end
            @(posedge clk); #1;
        end
        checks++; if (hs_n < 2) begin failures++; $display("FAIL stall_hs_count: got %0d exp >=2", hs_n); end
    endtask

    task automatic test_ebreak();
        bit saw = 0;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
        @(negedge clk);
        if (inst_valid && inst_ready) begin
            if (q.size() != 0) exp = q.pop_front(); else exp = '1;
            checks++; pops++;
            if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
        end
        expect_from(32'h8000_0400);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        for (int i = 0; i < 40 && !saw; i++) begin
            @(negedge clk);
            if (inst_valid && inst_ready && pc == EBK_PC) saw = 1;
            if (inst_valid && inst_ready) begin
                if (q.size() != 0) exp = q.pop_front(); else exp = '1;
                checks++; pops++;
                if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
            end
            @(posedge clk); #1;
        end
        checks++; if (!saw) begin failures++; $display("FAIL ebreak_timeout: got none exp pop of %h", EBK_PC); end
`ifdef IFU_EBREAK_HALT_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if ({halted, imem_req_valid, inst_valid} !== 3'b100) begin
                failures++; $display("FAIL halt%0d: got halted/req/inst=%b%b%b exp 100", i, halted, imem_req_valid, inst_valid);
            end
        end
`else
        saw = 0;
        for (int i = 0; i < 20 && !saw; i++) begin
            @(negedge clk);
            if (inst_valid && inst_ready && pc == EBK_PC + 32'd4) saw = 1;
            if (inst_valid && inst_ready) begin
                if (q.size() != 0) exp = q.pop_front(); else exp = '1;
                checks++; pops++;
                if ({pc, inst} !== exp) begin failures++; $display("FAIL sb_pop: got %h/%h exp %h/%h", pc, inst, exp.pc, exp.inst); end
            end
            checks++; if (halted !== 1'b0) begin failures++; $display("FAIL no_halt: got %b exp 0", halted); end
            @(posedge clk); #1;
        end
        checks++; if (!saw) begin failures++; $display("FAIL past_ebreak: got none exp pop of %h", EBK_PC + 32'd4); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rsp_pop();
        test_req_stall();
        test_ebreak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
